viterbi_frame_ctrl: RTL



---
 rtl/viterbi_pkg.sv | 31 +++
 rtl/vfc_capture.sv | 96 +++++++++
 rtl/viterbi_frame_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/viterbi_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : viterbi_pkg
//  Purpose  : Shared types, default sizing constants and helper functions for
//             the Viterbi frame sequencer (viterbi_frame_ctrl, vfc_capture).
//  Contents : vfc_state_t       - sequencer state encoding
//             VFC_FRAME_W/TAIL/DEC_LAT - default frame geometry
//             clog2_p1(x)       - bits needed to hold the value x
//  Revision : 1.0 - initial release
// ============================================================================
package viterbi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEND  = 3'd1,
    FLUSH = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } vfc_state_t;

  localparam int VFC_FRAME_W = 32;
  localparam int VFC_TAIL    = 8;
  localparam int VFC_DEC_LAT = 64;

  // Width of a counter that must be able to hold the value x itself.
  function automatic int clog2_p1(input int x);
    return $clog2(x + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vfc_capture.sv
`default_nettype none
// ============================================================================
//  Module   : vfc_capture
//  Purpose  : Decoded-stream capture for the frame sequencer. Waits DEC_LAT
//             cycles after the first send cycle, then samples one decoded bit
//             per cycle into o_rx_data[j] and counts mismatches against the
//             frame that was sent.
//  Ports    : clk, rst (async, active-low)
//             i_start    - frame accepted this cycle (clears results)
//             i_abort    - cancel capture, results held as-is
//             i_frame    - payload being accepted (reference copy)
//             i_dec_bit  - decoded serial bit
//             o_cap_done - all bits captured (includes capture this cycle)
//             o_rx_data  - recovered payload, bit j = j-th decoded bit
//             o_err_ct   - mismatching bit positions
//  Revision : 1.0 - initial release
// ============================================================================
module vfc_capture import viterbi_pkg::*; #(
  parameter int FRAME_W = VFC_FRAME_W,
  parameter int DEC_LAT = VFC_DEC_LAT,
  parameter int CNT_W   = clog2_p1(VFC_DEC_LAT + VFC_FRAME_W)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_start,
  input  logic                         i_abort,
  input  logic [FRAME_W-1:0]           i_frame,
  input  logic                         i_dec_bit,
  output logic                         o_cap_done,
  output logic [FRAME_W-1:0]           o_rx_data,
  output logic [clog2_p1(FRAME_W)-1:0] o_err_ct
);

  localparam int IDX_W = $clog2(FRAME_W);
  localparam int ERR_W = clog2_p1(FRAME_W);

  logic               r_active;
  logic               r_complete;
  logic [CNT_W-1:0]   r_dly;
  logic [IDX_W-1:0]   r_idx;
  logic [FRAME_W-1:0] r_ref;
  logic [FRAME_W-1:0] r_rx;
  logic [ERR_W-1:0]   r_err;
  logic               w_cap;
  logic               w_last;

  // r_dly reads 0 in the first send cycle, so reaching DEC_LAT lines up with
  // bit 0 arriving on the decoder output; it then parks there while r_idx walks.
  assign w_cap  = r_active && (r_dly == CNT_W'(DEC_LAT));
  assign w_last = w_cap && (r_idx == IDX_W'(FRAME_W - 1));

  // Report completion in the same cycle as the final capture so the sequencer
  // can enter DONE right after it.
  assign o_cap_done = r_complete || w_last;
  assign o_rx_data  = r_rx;
  assign o_err_ct   = r_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_active   <= 1'b0;
      r_complete <= 1'b0;
      r_dly      <= '0;
      r_idx      <= '0;
      r_ref      <= '0;
      r_rx       <= '0;
      r_err      <= '0;
    end else if (i_start) begin
      r_active   <= 1'b1;
      r_complete <= 1'b0;
      r_dly      <= '0;
      r_idx      <= '0;
      r_ref      <= i_frame;
      r_rx       <= '0;
      r_err      <= '0;
    end else if (i_abort) begin
      r_active <= 1'b0;
    end else if (r_active) begin
      if (!w_cap) begin
        r_dly <= r_dly + CNT_W'(1);
      end else begin
        r_rx[r_idx] <= i_dec_bit;
        if (i_dec_bit != r_ref[r_idx]) begin
          r_err <= r_err + ERR_W'(1);
        end
        if (w_last) begin
          r_active   <= 1'b0;
          r_complete <= 1'b1;
        end else begin
          r_idx <= r_idx + IDX_W'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/viterbi_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : viterbi_frame_ctrl
//  Purpose  : Frame sequencer for the encode/channel/Viterbi-decode loop.
//             Accepts one frame per handshake, serializes it LSB-first onto
//             encoder_i followed by TAIL zero flush bits, captures the decoded
//             stream DEC_LAT cycles later and reports rx_data / err_ct with a
//             one-cycle done pulse.
//  Ports    : clk, rst (async, active-low)
//             frame_valid/frame_ready/frame_data - frame handshake
//             abort            - cancel the frame in flight
//             encoder_i, enable_encoder_i - serial stream to the encoder
//             decoder_o        - decoded serial bit
//             busy, done, rx_data, err_ct - status and results
//  Revision : 1.0 - initial release
// ============================================================================
module viterbi_frame_ctrl import viterbi_pkg::*; #(
  parameter int FRAME_W = VFC_FRAME_W,
  parameter int TAIL    = VFC_TAIL,
  parameter int DEC_LAT = VFC_DEC_LAT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         frame_valid,
  output logic                         frame_ready,
  input  logic [FRAME_W-1:0]           frame_data,
  input  logic                         abort,
  output logic                         encoder_i,
  output logic                         enable_encoder_i,
  input  logic                         decoder_o,
  output logic                         busy,
  output logic                         done,
  output logic [FRAME_W-1:0]           rx_data,
  output logic [clog2_p1(FRAME_W)-1:0] err_ct
);

  localparam int SPAN  = (FRAME_W + TAIL > DEC_LAT + FRAME_W) ? (FRAME_W + TAIL)
                                                              : (DEC_LAT + FRAME_W);
  localparam int CNT_W = clog2_p1(SPAN);

  vfc_state_t         r_state;
  logic [CNT_W-1:0]   r_ct;
  logic [FRAME_W-1:0] r_tx;
  logic               r_enc;
  logic               r_en;
  logic               r_done;
  logic               w_accept;
  logic               w_abort;
  logic               w_cap_done;

  assign frame_ready      = (r_state == IDLE);
  assign busy             = (r_state != IDLE);
  assign w_accept         = frame_valid && frame_ready;
  assign w_abort          = abort && busy;
  assign encoder_i        = r_enc;
  assign enable_encoder_i = r_en;
  assign done             = r_done;

  // Serial outputs are registered one step ahead: the bit loaded at an edge is
  // the one on the wire for the whole following state cycle. r_tx therefore
  // holds the not-yet-driven remainder of the payload.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_ct    <= '0;
      r_tx    <= '0;
      r_enc   <= 1'b0;
      r_en    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_abort) begin
        r_state <= IDLE;
        r_enc   <= 1'b0;
        r_en    <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_accept) begin
              r_state <= SEND;
              r_ct    <= '0;
              r_tx    <= frame_data >> 1;
              r_enc   <= frame_data[0];
              r_en    <= 1'b1;
            end
          end
          SEND: begin
            if (r_ct == CNT_W'(FRAME_W - 1)) begin
              r_state <= FLUSH;
              r_ct    <= '0;
              r_enc   <= 1'b0;
            end else begin
              r_ct  <= r_ct + CNT_W'(1);
              r_enc <= r_tx[0];
              r_tx  <= r_tx >> 1;
            end
          end
          FLUSH: begin
            if (r_ct == CNT_W'(TAIL - 1)) begin
              r_en <= 1'b0;
              if (w_cap_done) begin
                r_state <= DONE;
                r_done  <= 1'b1;
              end else begin
                r_state <= DRAIN;
              end
            end else begin
              r_ct <= r_ct + CNT_W'(1);
            end
          end
          DRAIN: begin
            if (w_cap_done) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end
          end
          DONE: begin
            r_state <= IDLE;
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  vfc_capture #(
    .FRAME_W (FRAME_W),
    .DEC_LAT (DEC_LAT),
    .CNT_W   (CNT_W)
  ) u_capture (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_accept),
    .i_abort    (w_abort),
    .i_frame    (frame_data),
    .i_dec_bit  (decoder_o),
    .o_cap_done (w_cap_done),
    .o_rx_data  (rx_data),
    .o_err_ct   (err_ct)
  );

endmodule
`default_nettype wire
